rr_arbiter8: RTL and testbench
==============================

RR_ARBITER8 -- requirements
Module: rr_arbiter8

Interface
REQ-001 The block SHALL have parameter MAX_HOLD, default 15: maximum consecutive cycles one grant may be held; legal range 2..15.
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst, input, 1, synchronous active-high reset sampled on the rising edge of clk.
REQ-004 The block SHALL have port req, input, 8, per-requester request; bit i high means requester i wants the shared resource.
REQ-005 The block SHALL have port gnt, output, 8, registered one-hot grant; all zero when no grant.
REQ-006 The block SHALL have port gnt_idx, output, 3, registered binary index of the granted requester (8:3 encoding of gnt).
REQ-007 The block SHALL have port gnt_valid, output, 1, registered; high exactly when gnt is non-zero.
REQ-008 The block SHALL have port preempt, output, 1, registered one-cycle pulse when a grant is force-released at MAX_HOLD.

Function
REQ-009 The block SHALL implement three states: IDLE, GRANT, RELEASE.
REQ-010 The block SHALL hold a 3-bit round-robin pointer ptr; the search order is ptr, ptr+1, ..., ptr+7, modulo 8.
REQ-011 In IDLE and RELEASE, if req is non-zero, the block SHALL select the first set bit in search order and enter GRANT at the next edge.
REQ-012 On entry to GRANT, the block SHALL drive gnt, gnt_idx and gnt_valid=1, giving a 1-cycle latency from sampled req to grant.
REQ-013 In IDLE and RELEASE with req equal to zero, the block SHALL go to or stay in IDLE with gnt=0, gnt_idx unchanged and gnt_valid=0.
REQ-014 gnt_idx SHALL always equal the binary index of the single set bit of gnt whenever gnt_valid=1.
REQ-015 The block SHALL keep a hold counter, cleared on entry to GRANT and incremented on each GRANT cycle.
REQ-016 In GRANT, if req[gnt_idx]=0 is sampled, the block SHALL enter RELEASE at the next edge (normal release) with preempt=0.
REQ-017 In GRANT, if req[gnt_idx]=1 and the hold counter equals MAX_HOLD-1, the block SHALL enter RELEASE and pulse preempt for that one RELEASE cycle, so gnt is high exactly MAX_HOLD cycles.
REQ-018 If the request drops in the same cycle the limit is reached, the block SHALL treat it as a normal release with preempt=0.
REQ-019 On every transition into RELEASE, the block SHALL set ptr to gnt_idx+1 modulo 8 (7 wraps to 0).
REQ-020 In RELEASE, the block SHALL drive gnt=0 and gnt_valid=0, so at least one dead cycle separates any two grants.
REQ-021 Changes on req[j] for j other than gnt_idx SHALL NOT affect an active grant; the arbitration is non-preemptive except via MAX_HOLD.
REQ-022 After a forced release, a still-requesting previous holder SHALL have the lowest priority, and SHALL be re-granted after RELEASE only if no other bit is set.
REQ-023 All outputs SHALL be registered; no output SHALL depend combinationally on req.

Reset
REQ-024 With rst=1 at a rising edge, the block SHALL set state=IDLE, gnt=0, gnt_idx=0, gnt_valid=0, preempt=0, ptr=0 and hold counter=0, regardless of req.
REQ-025 Reset asserted during GRANT SHALL clear the grant at that same edge, and ptr SHALL return to 0, not advance.
REQ-026 On the first edge after rst deasserts, the block SHALL arbitrate normally from IDLE.

Verification
REQ-027 Single request: after reset, req=8'b00000001 -> next edge gnt=00000001, gnt_idx=000, gnt_valid=1; drop req -> one edge later RELEASE with gnt=0, then IDLE.
REQ-028 Pointer advance: req=8'b00001001 from reset -> requester 0 granted first; drop req[0] -> RELEASE cycle, then gnt=00001000, gnt_idx=011.
REQ-029 Full rotation and wrap: req=8'hFF, each holder drops its bit one cycle after seeing its grant and re-raises it after -> grant order 0,1,2,...,7,0, with one dead cycle between grants.
REQ-030 Forced release with MAX_HOLD=4, req=8'b00000110 held constant -> gnt=00000010 for exactly 4 cycles, preempt=1 for the RELEASE cycle, then gnt=00000100; with req=8'b00000010 only, requester 1 is re-granted after one dead cycle.
REQ-031 Reset mid-grant: requester 5 granted, rst=1 for one edge -> gnt=0, gnt_valid=0, gnt_idx=0, ptr=0; with req=8'b00100001 after reset, requester 0 is granted first.
REQ-032 Simultaneous drop at limit, MAX_HOLD=4: req[gnt_idx] falls in the 4th grant cycle -> RELEASE with preempt=0.

Source files
------------

// File: rtl/rr_arbiter8.sv
// Eight-way round-robin arbiter with registered one-hot grant.
// A grant is force-released after MAX_HOLD cycles if its requester keeps asking.
module rr_arbiter8 #(
    parameter int MAX_HOLD = 15
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] req,
    output logic [7:0] gnt,
    output logic [2:0] gnt_idx,
    output logic       gnt_valid,
    output logic       preempt
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT   = 2'd1,
        RELEASE = 2'd2
    } state_t;

    localparam logic [3:0] HOLD_LIM = 4'(MAX_HOLD - 1);

    state_t     state;
    state_t     state_nx;
    logic [2:0] ptr;
    logic [2:0] ptr_nx;
    logic [2:0] pick;
    logic [2:0] scan;
    logic [3:0] hold_cnt;
    logic [3:0] hold_nx;
    logic       found;
    logic       hold_req;
    logic       at_limit;
    logic [7:0] gnt_nx;
    logic [2:0] idx_nx;
    logic       valid_nx;
    logic       preempt_nx;

    // Scan from the far end so the closest set bit to ptr wins.
    always_comb begin
        found = 1'b0;
        pick  = ptr;
        scan  = ptr;
        for (int k = 7; k >= 0; k--) begin
            scan = ptr + 3'(k);
            if (req[scan]) begin
                found = 1'b1;
                pick  = scan;
            end
        end
    end

    assign hold_req = req[gnt_idx];
    assign at_limit = (hold_cnt == HOLD_LIM);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            ptr       <= 3'd0;
            hold_cnt  <= 4'd0;
            gnt       <= 8'd0;
            gnt_idx   <= 3'd0;
            gnt_valid <= 1'b0;
            preempt   <= 1'b0;
        end else begin
            state     <= state_nx;
            ptr       <= ptr_nx;
            hold_cnt  <= hold_nx;
            gnt       <= gnt_nx;
            gnt_idx   <= idx_nx;
            gnt_valid <= valid_nx;
            preempt   <= preempt_nx;
        end
    end

    always_comb begin
        state_nx = state;
        ptr_nx   = ptr;
        hold_nx  = hold_cnt;
        unique case (state)
            GRANT: begin
                hold_nx = hold_cnt + 4'd1;
                if (!hold_req || at_limit) begin
                    state_nx = RELEASE;
                    ptr_nx   = gnt_idx + 3'd1;
                end
            end
            IDLE, RELEASE: begin
                hold_nx  = 4'd0;
                state_nx = found ? GRANT : IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // A dropped request takes precedence over the limit: no preempt then.
    always_comb begin
        gnt_nx     = 8'd0;
        idx_nx     = gnt_idx;
        valid_nx   = 1'b0;
        preempt_nx = 1'b0;
        unique case (state)
            GRANT: begin
                if (state_nx == GRANT) begin
                    gnt_nx   = gnt;
                    valid_nx = 1'b1;
                end else begin
                    preempt_nx = hold_req && at_limit;
                end
            end
            IDLE, RELEASE: begin
                if (found) begin
                    gnt_nx   = 8'd1 << pick;
                    idx_nx   = pick;
                    valid_nx = 1'b1;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_rr_arbiter8.sv
// Bench for rr_arbiter8: per-cycle reference model compare
// plus directed scenarios with literal expectations.
module tb_rr_arbiter8;

    localparam int MH = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] req = 8'd0;
    logic [7:0] gnt;
    logic [2:0] gnt_idx;
    logic       gnt_valid;
    logic       preempt;

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 1'b0;

    int holder = -1;
    int held   = 0;
    int m_ptr  = 0;
    int m_idx  = 0;
    bit m_pre  = 1'b0;

    rr_arbiter8 #(.MAX_HOLD(MH)) dut (
        .clk(clk),
        .rst(rst),
        .req(req),
        .gnt(gnt),
        .gnt_idx(gnt_idx),
        .gnt_valid(gnt_valid),
        .preempt(preempt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h expected %0h",
                     name, $time, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    // Reference: who holds the resource, how long, and where the search starts.
    always @(posedge clk) begin
        if (rst) begin
            holder = -1;
            held   = 0;
            m_ptr  = 0;
            m_idx  = 0;
            m_pre  = 1'b0;
        end else if (holder >= 0) begin
            held++;
            m_pre = 1'b0;
            if (!req[holder] || held == MH) begin
                m_pre  = req[holder] ? 1'b1 : 1'b0;
                m_ptr  = (holder + 1) % 8;
                holder = -1;
            end
        end else begin
            m_pre = 1'b0;
            for (int k = 0; k < 8; k++) begin
                if (holder < 0 && req[(m_ptr + k) % 8]) begin
                    holder = (m_ptr + k) % 8;
                    m_idx  = holder;
                    held   = 0;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("model gnt", {24'd0, gnt},
                (holder >= 0) ? (32'd1 << holder) : 32'd0);
            chk("model gnt_valid", {31'd0, gnt_valid},
                (holder >= 0) ? 32'd1 : 32'd0);
            chk("model gnt_idx", {29'd0, gnt_idx}, 32'(m_idx));
            chk("model preempt", {31'd0, preempt}, {31'd0, m_pre});
        end
    end

    initial begin
        req = 8'hFF;
        tick();
        chk_en = 1'b1;
        chk("reset gnt", {24'd0, gnt}, 32'h00);
        chk("reset valid", {31'd0, gnt_valid}, 32'd0);
        chk("reset idx", {29'd0, gnt_idx}, 32'd0);
        chk("reset preempt", {31'd0, preempt}, 32'd0);

        // single request
        rst = 1'b0;
        req = 8'h01;
        tick();
        chk("single gnt", {24'd0, gnt}, 32'h01);
        chk("single valid", {31'd0, gnt_valid}, 32'd1);
        req = 8'h00;
        tick();
        chk("single release", {24'd0, gnt}, 32'h00);
        tick();
        chk("single idle", {31'd0, gnt_valid}, 32'd0);

        // pointer advance
        do_reset();
        req = 8'h09;
        tick();
        chk("ptr first", {24'd0, gnt}, 32'h01);
        req = 8'h08;
        tick();
        chk("ptr dead", {24'd0, gnt}, 32'h00);
        tick();
        chk("ptr second", {24'd0, gnt}, 32'h08);
        chk("ptr idx", {29'd0, gnt_idx}, 32'd3);
        req = 8'h00;
        tick();
        tick();

        // full rotation with wrap
        do_reset();
        req = 8'hFF;
        for (int i = 0; i < 9; i++) begin
            tick();
            chk("rot gnt", {24'd0, gnt}, 32'd1 << (i % 8));
            req = 8'hFF & ~(8'd1 << (i % 8));
            tick();
            chk("rot dead", {24'd0, gnt}, 32'h00);
            req = 8'hFF;
        end
        req = 8'h00;
        tick();
        tick();
        tick();

        // forced release hands over to the other requester
        do_reset();
        req = 8'h06;
        for (int i = 0; i < MH; i++) begin
            tick();
            chk("force hold", {24'd0, gnt}, 32'h02);
        end
        tick();
        chk("force dead", {24'd0, gnt}, 32'h00);
        chk("force preempt", {31'd0, preempt}, 32'd1);
        tick();
        chk("force next", {24'd0, gnt}, 32'h04);
        chk("force pre clr", {31'd0, preempt}, 32'd0);
        req = 8'h00;
        tick();
        tick();

        // lone requester is re-granted after preemption
        do_reset();
        req = 8'h02;
        for (int i = 0; i < MH; i++) tick();
        tick();
        chk("lone preempt", {31'd0, preempt}, 32'd1);
        tick();
        chk("lone regrant", {24'd0, gnt}, 32'h02);
        chk("lone idx", {29'd0, gnt_idx}, 32'd1);
        req = 8'h00;
        tick();
        tick();

        // reset mid-grant after the pointer has moved
        do_reset();
        req = 8'h01;
        tick();
        req = 8'h00;
        tick();
        req = 8'h20;
        tick();
        chk("mid gnt", {24'd0, gnt}, 32'h20);
        rst = 1'b1;
        tick();
        chk("mid rst gnt", {24'd0, gnt}, 32'h00);
        chk("mid rst valid", {31'd0, gnt_valid}, 32'd0);
        chk("mid rst idx", {29'd0, gnt_idx}, 32'd0);
        rst = 1'b0;
        req = 8'h21;
        tick();
        chk("mid after", {24'd0, gnt}, 32'h01);
        req = 8'h00;
        tick();
        tick();

        // request drops in the limit cycle; other bits must not disturb
        do_reset();
        req = 8'h02;
        tick();
        req = 8'h0B;
        tick();
        req = 8'h0A;
        tick();
        tick();
        chk("drop 4th", {24'd0, gnt}, 32'h02);
        req = 8'h08;
        tick();
        chk("drop dead", {24'd0, gnt}, 32'h00);
        chk("drop preempt", {31'd0, preempt}, 32'd0);
        tick();
        chk("drop next", {24'd0, gnt}, 32'h08);
        req = 8'h00;
        tick();
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
